// File: rtl/axi_lite_pkg.sv
// AXI4-Lite shared definitions: response codes and protection type.
// Used by the RAM slave, the ROM slave and the CPU master.
package axi_lite_pkg;

  // Response codes carried on BRESP / RRESP.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // AxPROT encoding; carried through the bus but not interpreted by the slaves.
  typedef logic [2:0] prot_t;

endpackage

// File: rtl/axi_lite_ram_mem.sv
// Byte-enable word array for axi_lite_ram.
// One write port (index, data, strobe, enable) and one synchronous read port.
// The read register clears on reset and can be forced to zero for
// rejected (misaligned) reads. A read and a write to the same word on the
// same edge return the old contents.
module axi_lite_ram_mem
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic                    i_rd_en,
  input  logic                    i_rd_zero,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Byte-lane writes; lanes with strobe low keep their contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (i_wr_strb[i]) begin
          ram[i_wr_idx][i*8 +: 8] <= i_wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Registered read; holds its value between reads so RDATA stays stable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_zero ? '0 : ram[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave RAM (CPU data memory). Sees byte offsets only; the
// interconnect removes the system base address.
// Independent read and write FSMs, one transaction outstanding on each.
// Handshake rule on every channel: a transfer happens on the rising edge
// where both VALID and READY are high; the master holds VALID and payload
// until then, and READY here never depends combinationally on VALID.
// Optional build macro AXI_RAM_ALIGN_CHECK_EN: misaligned addresses get
// SLVERR, misaligned writes are dropped and misaligned reads return zero.
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]              axi_awprot,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]              axi_arprot,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP}          rd_state_t;

  // ---------------- write channel ----------------
  wr_state_t        r_wr_state, w_wr_state_nxt;
  logic             r_awready,  w_awready_nxt;
  logic             r_wready,   w_wready_nxt;
  logic             r_bvalid,   w_bvalid_nxt;
  resp_t            r_bresp,    w_bresp_nxt;
  logic [IDX_W-1:0] r_aw_idx,   w_aw_idx_nxt;
  logic             r_aw_err,   w_aw_err_nxt;
  logic             w_mem_wr_en;
  logic             w_aw_misaligned;

  // ---------------- read channel ----------------
  rd_state_t        r_rd_state, w_rd_state_nxt;
  logic             r_arready,  w_arready_nxt;
  logic             r_rvalid,   w_rvalid_nxt;
  resp_t            r_rresp,    w_rresp_nxt;
  logic             w_mem_rd_en;
  logic             w_ar_misaligned;

`ifdef AXI_RAM_ALIGN_CHECK_EN
  assign w_aw_misaligned = |axi_awaddr[OFF_W-1:0];
  assign w_ar_misaligned = |axi_araddr[OFF_W-1:0];
`else
  assign w_aw_misaligned = 1'b0;
  assign w_ar_misaligned = 1'b0;
`endif

  // Protection bits and byte-offset bits carry no meaning for storage.
  logic w_unused_ok;
  assign w_unused_ok = ^{axi_awprot, axi_arprot,
                         axi_awaddr[OFF_W-1:0], axi_araddr[OFF_W-1:0]};

  // Write FSM next state and next registered outputs.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_awready_nxt  = r_awready;
    w_wready_nxt   = r_wready;
    w_bvalid_nxt   = r_bvalid;
    w_bresp_nxt    = r_bresp;
    w_aw_idx_nxt   = r_aw_idx;
    w_aw_err_nxt   = r_aw_err;
    w_mem_wr_en    = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        w_awready_nxt = 1'b1;
        if (axi_awvalid && r_awready) begin
          w_aw_idx_nxt   = axi_awaddr[ADDR_WIDTH-1:OFF_W];
          w_aw_err_nxt   = w_aw_misaligned;
          w_awready_nxt  = 1'b0;
          w_wready_nxt   = 1'b1;
          w_wr_state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (axi_wvalid && r_wready) begin
          w_mem_wr_en    = ~r_aw_err;
          w_wready_nxt   = 1'b0;
          w_bvalid_nxt   = 1'b1;
          w_bresp_nxt    = r_aw_err ? RESP_SLVERR : RESP_OKAY;
          w_wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_bready && r_bvalid) begin
          w_bvalid_nxt   = 1'b0;
          w_awready_nxt  = 1'b1;
          w_wr_state_nxt = WR_IDLE;
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM state and output registers.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_idx   <= '0;
      r_aw_err   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_bresp    <= w_bresp_nxt;
      r_aw_idx   <= w_aw_idx_nxt;
      r_aw_err   <= w_aw_err_nxt;
    end
  end

  // Read FSM next state and next registered outputs.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_arready_nxt  = r_arready;
    w_rvalid_nxt   = r_rvalid;
    w_rresp_nxt    = r_rresp;
    w_mem_rd_en    = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        w_arready_nxt = 1'b1;
        if (axi_arvalid && r_arready) begin
          w_mem_rd_en    = 1'b1;
          w_rresp_nxt    = w_ar_misaligned ? RESP_SLVERR : RESP_OKAY;
          w_rvalid_nxt   = 1'b1;
          w_arready_nxt  = 1'b0;
          w_rd_state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi_rready && r_rvalid) begin
          w_rvalid_nxt   = 1'b0;
          w_arready_nxt  = 1'b1;
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state and output registers.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rresp    <= w_rresp_nxt;
    end
  end

  // Storage; a write coinciding with reset is dropped.
  axi_lite_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .i_clk      (axi_aclk),
    .i_rst_n    (axi_aresetn),
    .i_wr_en    (w_mem_wr_en & axi_aresetn),
    .i_wr_idx   (r_aw_idx),
    .i_wr_data  (axi_wdata),
    .i_wr_strb  (axi_wstrb),
    .i_rd_en    (w_mem_rd_en),
    .i_rd_zero  (w_ar_misaligned),
    .i_rd_idx   (axi_araddr[ADDR_WIDTH-1:OFF_W]),
    .o_rd_data  (axi_rdata)
  );

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: reset values, table of write/read
// vectors, then hand sequences for backpressure, same-edge read/write,
// address wrap and (when AXI_RAM_ALIGN_CHECK_EN is defined) misalignment.
module tb_axi_lite_ram;

  localparam int DW = 32;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  logic            axi_aresetn = 1'b0;
  logic [AW-1:0]   axi_awaddr  = '0;
  logic [2:0]      axi_awprot  = '0;
  logic            axi_awvalid = 1'b0;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata   = '0;
  logic [DW/8-1:0] axi_wstrb   = '0;
  logic            axi_wvalid  = 1'b0;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready  = 1'b0;
  logic [AW-1:0]   axi_araddr  = '0;
  logic [2:0]      axi_arprot  = '0;
  logic            axi_arvalid = 1'b0;
  logic            axi_arready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rvalid;
  logic            axi_rready  = 1'b0;

  axi_lite_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .axi_awaddr  (axi_awaddr),
    .axi_awprot  (axi_awprot),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arprot  (axi_arprot),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic sig(input int id);
    case (id)
      0:       return axi_awready;
      1:       return axi_wready;
      2:       return axi_bvalid;
      3:       return axi_arready;
      4:       return axi_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int id, input string name);
    int n = 0;
    while (sig(id) !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: still low after 50 cycles, expected 1", name);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, output logic [1:0] resp);
    axi_awaddr  = a;
    axi_awvalid = 1'b1;
    wait_sig(0, "awready");
    tick();
    axi_awvalid = 1'b0;
    axi_wdata   = d;
    axi_wstrb   = s;
    axi_wvalid  = 1'b1;
    wait_sig(1, "wready");
    tick();
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b1;
    wait_sig(2, "bvalid");
    resp = axi_bresp;
    tick();
    axi_bready  = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [1:0] resp);
    axi_araddr  = a;
    axi_arvalid = 1'b1;
    wait_sig(3, "arready");
    tick();
    axi_arvalid = 1'b0;
    check("rvalid_one_cycle_after_ar", {31'd0, axi_rvalid}, 32'd1);
    d    = axi_rdata;
    resp = axi_rresp;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit              is_wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;     // write data, or expected read data
    logic [DW/8-1:0] strb;
    logic [1:0]      exp_resp;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    logic [31:0]   wide_addr;

    vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, 16'h0010, 32'hDEADBEEF, 4'h0, 2'b00};
    vecs[2]  = '{1'b1, 16'h0020, 32'h11223344, 4'hF, 2'b00};
    vecs[3]  = '{1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 2'b00};
    vecs[4]  = '{1'b0, 16'h0020, 32'h11BB33DD, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, 2'b00};
    vecs[6]  = '{1'b1, 16'h0040, 32'hFFFFFFFF, 4'h0, 2'b00};
    vecs[7]  = '{1'b0, 16'h0040, 32'hCAFEF00D, 4'h0, 2'b00};
    vecs[8]  = '{1'b1, 16'h0044, 32'h00000000, 4'hF, 2'b00};
    vecs[9]  = '{1'b1, 16'h0044, 32'hA1B2C3D4, 4'h8, 2'b00};
    vecs[10] = '{1'b0, 16'h0044, 32'hA1000000, 4'h0, 2'b00};
    vecs[11] = '{1'b0, 16'h0020, 32'h11BB33DD, 4'h0, 2'b00};

    // Reset held: all outputs at their reset values.
    repeat (3) tick();
    check("rst_awready", {31'd0, axi_awready}, 32'd0);
    check("rst_wready",  {31'd0, axi_wready},  32'd0);
    check("rst_bvalid",  {31'd0, axi_bvalid},  32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd0);
    check("rst_rvalid",  {31'd0, axi_rvalid},  32'd0);
    check("rst_rdata",   axi_rdata,            32'd0);
    check("rst_bresp",   {30'd0, axi_bresp},   32'd0);
    check("rst_rresp",   {30'd0, axi_rresp},   32'd0);

    axi_aresetn = 1'b1;
    tick();
    check("post_rst_awready", {31'd0, axi_awready}, 32'd1);
    check("post_rst_arready", {31'd0, axi_arready}, 32'd1);
    check("post_rst_bvalid",  {31'd0, axi_bvalid},  32'd0);
    check("post_rst_rvalid",  {31'd0, axi_rvalid},  32'd0);

    // A W beat without an AW handshake is never accepted.
    axi_wvalid = 1'b1;
    axi_wdata  = 32'hBAD0BAD0;
    axi_wstrb  = 4'hF;
    tick();
    tick();
    check("wready_before_aw", {31'd0, axi_wready}, 32'd0);
    axi_wvalid = 1'b0;

    // Table-driven writes and reads.
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        check($sformatf("v%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
      end else begin
        exp_q.push_back(vecs[i].data);
        do_read(vecs[i].addr, rd, rs);
        check($sformatf("v%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
        check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
      end
    end

    // B channel backpressure.
    axi_awaddr  = 16'h0050;
    axi_awvalid = 1'b1;
    wait_sig(0, "bp_awready");
    tick();
    axi_awvalid = 1'b0;
    axi_wdata   = 32'h01020304;
    axi_wstrb   = 4'hF;
    axi_wvalid  = 1'b1;
    wait_sig(1, "bp_wready");
    tick();
    axi_wvalid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_bvalid_hold%0d", c),  {31'd0, axi_bvalid},  32'd1);
      check($sformatf("bp_awready_low%0d", c), {31'd0, axi_awready}, 32'd0);
      tick();
    end
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check("bp_bvalid_drop",  {31'd0, axi_bvalid},  32'd0);
    check("bp_awready_back", {31'd0, axi_awready}, 32'd1);

    // R channel backpressure.
    axi_araddr  = 16'h0010;
    axi_arvalid = 1'b1;
    wait_sig(3, "bp_arready");
    tick();
    axi_arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_rvalid_hold%0d", c), {31'd0, axi_rvalid},  32'd1);
      check($sformatf("bp_rdata_hold%0d", c),  axi_rdata,            32'hDEADBEEF);
      check($sformatf("bp_arready_low%0d", c), {31'd0, axi_arready}, 32'd0);
      tick();
    end
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("bp_rvalid_drop",  {31'd0, axi_rvalid},  32'd0);
    check("bp_arready_back", {31'd0, axi_arready}, 32'd1);

    // Same edge: AR handshake and W handshake to one word -> old data.
    do_write(16'h0030, 32'h00000000, 4'hF, rs);
    check("same_pre_bresp", {30'd0, rs}, 32'd0);
    axi_awaddr  = 16'h0030;
    axi_awvalid = 1'b1;
    wait_sig(0, "same_awready");
    tick();
    axi_awvalid = 1'b0;
    check("same_wready",  {31'd0, axi_wready},  32'd1);
    check("same_arready", {31'd0, axi_arready}, 32'd1);
    axi_wdata   = 32'h12345678;
    axi_wstrb   = 4'hF;
    axi_wvalid  = 1'b1;
    axi_araddr  = 16'h0030;
    axi_arvalid = 1'b1;
    tick();
    axi_wvalid  = 1'b0;
    axi_arvalid = 1'b0;
    check("same_rvalid", {31'd0, axi_rvalid}, 32'd1);
    check("same_rdata_old", axi_rdata, 32'h00000000);
    check("same_bvalid", {31'd0, axi_bvalid}, 32'd1);
    axi_rready = 1'b1;
    axi_bready = 1'b1;
    tick();
    axi_rready = 1'b0;
    axi_bready = 1'b0;
    do_read(16'h0030, rd, rs);
    check("same_rdata_new", rd, 32'h12345678);

    // Top word and address wrap.
    do_write(16'hFFFC, 32'h5A5A5A5A, 4'hF, rs);
    check("wrap_bresp", {30'd0, rs}, 32'd0);
    wide_addr = 32'h0001FFFC;
    do_read(wide_addr[15:0], rd, rs);
    check("wrap_rdata", rd, 32'h5A5A5A5A);
    check("wrap_rresp", {30'd0, rs}, 32'd0);

`ifdef AXI_RAM_ALIGN_CHECK_EN
    do_read(16'h0012, rd, rs);
    check("mis_rd_rresp", {30'd0, rs}, 32'd2);
    check("mis_rd_rdata", rd, 32'h00000000);
    do_write(16'h0011, 32'hFFFFFFFF, 4'hF, rs);
    check("mis_wr_bresp", {30'd0, rs}, 32'd2);
    do_read(16'h0010, rd, rs);
    check("mis_wr_untouched", rd, 32'hDEADBEEF);
    check("mis_wr_rresp_ok", {30'd0, rs}, 32'd0);
`else
    do_read(16'h0012, rd, rs);
    check("off_rd_rresp", {30'd0, rs}, 32'd0);
    check("off_rd_rdata", rd, 32'hDEADBEEF);
    do_write(16'h0062, 32'h600D600D, 4'hF, rs);
    check("off_wr_bresp", {30'd0, rs}, 32'd0);
    do_read(16'h0060, rd, rs);
    check("off_wr_rdata", rd, 32'h600D600D);
`endif

    // Reset mid-transaction: AW accepted, no W yet -> nothing outstanding.
    axi_awaddr  = 16'h0070;
    axi_awvalid = 1'b1;
    wait_sig(0, "abort_awready");
    tick();
    axi_awvalid = 1'b0;
    axi_aresetn = 1'b0;
    tick();
    check("abort_wready",  {31'd0, axi_wready}, 32'd0);
    check("abort_bvalid",  {31'd0, axi_bvalid}, 32'd0);
    axi_aresetn = 1'b1;
    tick();
    check("abort_awready_back", {31'd0, axi_awready}, 32'd1);
    do_read(16'h0020, rd, rs);
    check("abort_ram_kept", rd, 32'h11BB33DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_ram.md
Name: axi_lite_ram

Overview:
- AXI4-Lite slave RAM providing the CPU's data memory. In the system it is mapped at 0x1000_0000; the interconnect subtracts the base, so this block sees offsets only.
- Byte-addressed, word-wide, with byte-strobe writes.
- Read and write channels are independent; each has one transaction outstanding.
- Memory contents are not initialised by reset.

Parameters:
- DATA_WIDTH  32  data bus width in bits; multiple of 8.
- ADDR_WIDTH  16  byte-address width (16 gives 64 KB). Depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.

Ports:
- axi_aclk  in  1  clock; everything is on the rising edge.
- axi_aresetn  in  1  reset, synchronous, active-low.
- axi_awaddr  in  ADDR_WIDTH  write byte address.
- axi_awprot  in  3  ignored.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_wdata  in  DATA_WIDTH  write data.
- axi_wstrb  in  DATA_WIDTH/8  byte enables.
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_bresp  out  2  write response.
- axi_bvalid  out  1  write response valid.
- axi_bready  in  1  write response ready.
- axi_araddr  in  ADDR_WIDTH  read byte address.
- axi_arprot  in  3  ignored.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_rdata  out  DATA_WIDTH  read data.
- axi_rresp  out  2  read response.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.

Behaviour:
- Storage:
  - Array named ram, words of DATA_WIDTH bits.
  - Word index = addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - Addresses wrap modulo 2^ADDR_WIDTH.
- All outputs are registered.
- Reset (axi_aresetn=0 at a clock edge):
  - awready, wready, bvalid, arready, rvalid = 0; rdata = 0; bresp = rresp = 2'b00.
  - Both FSMs go to IDLE. The first edge after release raises awready and arready.
  - Reset mid-transaction aborts it with no response issued. RAM is written only if the W handshake already completed.
- Write FSM, states IDLE, DATA, RESP:
  - IDLE: awready=1. On awvalid&&awready, latch the address, awready←0, wready←1, go to DATA.
  - DATA: wready=1. On wvalid&&wready, write each byte i where wstrb[i]=1; bytes with strobe 0 are unchanged. Then wready←0, bvalid←1, bresp←OKAY, go to RESP.
  - RESP: hold bvalid until bready. Then bvalid←0, awready←1, go to IDLE.
  - wready is never asserted before the AW handshake, so W beats for other slaves sharing the bus are not consumed.
  - wstrb=0 is a legal no-op write and still gets an OKAY response.
- Read FSM, states IDLE, RESP:
  - IDLE: arready=1. On arvalid&&arready, rdata←ram[index], rresp←OKAY, rvalid←1, arready←0, go to RESP. Latency: rvalid rises the edge after the AR handshake.
  - RESP: hold rvalid and rdata stable until rready. Then rvalid←0, arready←1, go to IDLE.
- Simultaneous events:
  - A read accepted on the same edge as a write to the same word returns the old data (read-before-write).
  - Read and write FSMs run concurrently with no arbitration.
  - A valid asserted while its ready is low is simply held by the master. No state is affected.
- Throughput: one write per 3 cycles minimum, one read per 2 cycles minimum.

Optional Feature:
- Macro: AXI_RAM_ALIGN_CHECK_EN.
- Defined:
  - An address whose byte-offset bits are nonzero gets resp=SLVERR (2'b10).
  - A misaligned write completes its handshakes but writes nothing.
  - A misaligned read returns rdata=0 with SLVERR.
- Undefined: offset bits are ignored and every response is OKAY.

Decomposition:
- Package axi_lite_pkg:
  - resp typedef (2 bits) with constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - prot typedef (3 bits).
  - Shared with the rom slave and the CPU master.
- One natural sub-module: axi_lite_ram_mem, the byte-enable word array. It takes a write port (index, data, strobe, enable) and a synchronous read port. The two FSMs stay in the top module.

Test Plan:
1. Reset, then idle → all outputs as listed at reset while axi_aresetn=0. awready=arready=1 one edge after release; bvalid=rvalid=0.
2. Write 0xDEADBEEF to 0x0010 with wstrb=0xF, then read 0x0010 → bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY, rvalid one cycle after the AR handshake.
3. Write 0x11223344 to 0x0020, then 0xAABBCCDD with wstrb=0x5, then read 0x0020 → 0x11BB33DD.
4. Hold bready=0 for 5 cycles after a write, and rready=0 for 5 cycles after a read of 0x0010 → bvalid, rvalid and rdata=0xDEADBEEF held stable. awready and arready stay 0 until the respective handshake.
5. Same edge: AR and W handshakes to 0x0030 (old value 0x0, new 0x12345678) → read returns 0x0. A subsequent read returns 0x12345678.
6. Write 0x5A5A5A5A to 0xFFFC, then read 0x1FFFC with 32-bit address truncated to 16 bits → 0x5A5A5A5A. With AXI_RAM_ALIGN_CHECK_EN, a read of 0x0012 → rresp=SLVERR, rdata=0.
